// File: rtl/dmem_arbiter_if.sv
// Bundles the pipeline, auxiliary and data-memory buses seen by dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if;
   logic        pipe_read;
   logic        pipe_write;
   logic [31:0] pipe_addr;
   logic [31:0] pipe_wdata;
   logic [31:0] pipe_rdata;
   logic        pipe_stall;

   logic        aux_req;
   logic        aux_we;
   logic [31:0] aux_addr;
   logic [31:0] aux_wdata;
   logic        aux_gnt;
   logic        aux_rvalid;
   logic [31:0] aux_rdata;

   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  pipe_read, pipe_write, pipe_addr, pipe_wdata,
      output pipe_rdata, pipe_stall,
      input  aux_req, aux_we, aux_addr, aux_wdata,
      output aux_gnt, aux_rvalid, aux_rdata,
      output mem_we, mem_re, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output pipe_read, pipe_write, pipe_addr, pipe_wdata,
      input  pipe_rdata, pipe_stall,
      output aux_req, aux_we, aux_addr, aux_wdata,
      input  aux_gnt, aux_rvalid, aux_rdata,
      input  mem_we, mem_re, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the MEM stage (priority) and an
// auxiliary requester, forcing an aux slot after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   dmem_arbiter_if.slave    bus,
   output logic [CNT_W-1:0] pipe_acc_cnt,
   output logic [CNT_W-1:0] aux_acc_cnt
);

   localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0]    starve_q, starve_d;
   logic             aux_rvalid_q, aux_rvalid_d;
   logic [31:0]      aux_rdata_q, aux_rdata_d;
   logic [CNT_W-1:0] pipe_cnt_q, pipe_cnt_d;
   logic [CNT_W-1:0] aux_cnt_q, aux_cnt_d;

   logic pipe_req;
   logic pipe_go;
   logic aux_gnt;
   logic pipe_load;

   // Grant and memory mux; reset gates every enable so nothing reaches memory.
   always_comb begin
      pipe_req  = bus.pipe_read | bus.pipe_write;
      aux_gnt   = ~reset & bus.aux_req & (~pipe_req | (starve_q == STARVE_MAX));
      pipe_go   = ~reset & pipe_req & ~aux_gnt;
      pipe_load = pipe_go & bus.pipe_read & ~bus.pipe_write;

      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;
      if (pipe_go) begin
         bus.mem_we    = bus.pipe_write;
         bus.mem_re    = bus.pipe_read & ~bus.pipe_write;
         bus.mem_addr  = bus.pipe_addr;
         bus.mem_wdata = bus.pipe_wdata;
      end else if (aux_gnt) begin
         bus.mem_we    = bus.aux_we;
         bus.mem_re    = ~bus.aux_we;
         bus.mem_addr  = bus.aux_addr;
         bus.mem_wdata = bus.aux_wdata;
      end

      bus.pipe_rdata = pipe_load ? bus.mem_rdata : 32'd0;
      bus.pipe_stall = pipe_req & aux_gnt;
      bus.aux_gnt    = aux_gnt;
   end

   // Starvation tracking, aux read capture and access statistics.
   always_comb begin
      starve_d     = starve_q;
      aux_rvalid_d = aux_gnt & ~bus.aux_we;
      aux_rdata_d  = aux_rdata_q;
      pipe_cnt_d   = pipe_cnt_q;
      aux_cnt_d    = aux_cnt_q;

      if (aux_gnt) begin
         starve_d = '0;
      end else if (bus.aux_req && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end

      if (aux_gnt && !bus.aux_we) begin
         aux_rdata_d = bus.mem_rdata;
      end
      if (pipe_go) begin
         pipe_cnt_d = pipe_cnt_q + 1'b1;
      end
      if (aux_gnt) begin
         aux_cnt_d = aux_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_q     <= '0;
         aux_rvalid_q <= 1'b0;
         aux_rdata_q  <= 32'd0;
         pipe_cnt_q   <= '0;
         aux_cnt_q    <= '0;
      end else begin
         starve_q     <= starve_d;
         aux_rvalid_q <= aux_rvalid_d;
         aux_rdata_q  <= aux_rdata_d;
         pipe_cnt_q   <= pipe_cnt_d;
         aux_cnt_q    <= aux_cnt_d;
      end
   end

   assign bus.aux_rvalid = aux_rvalid_q;
   assign bus.aux_rdata  = aux_rdata_q;
   assign pipe_acc_cnt   = pipe_cnt_q;
   assign aux_acc_cnt    = aux_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;
   localparam int LIMIT = 4;
   localparam int CNT_W = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dmem_arbiter_if bus ();
   logic [CNT_W-1:0] pipe_acc_cnt;
   logic [CNT_W-1:0] aux_acc_cnt;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .pipe_acc_cnt (pipe_acc_cnt),
      .aux_acc_cnt  (aux_acc_cnt)
   );

   // Environment memory feeding the DUT's combinational read port.
   logic [31:0] env_mem [256];
   assign bus.mem_rdata = env_mem[bus.mem_addr[9:2]];
   always @(posedge clock) begin
      if (bus.mem_we) env_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
   end

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns memory this cycle and what each party sees.
   logic [31:0] ref_mem [256];
   int          aux_waited;
   bit          m_rvalid;
   logic [31:0] m_rdata;
   int          m_pcnt, m_acnt;

   bit          e_gnt, e_go, e_stall, e_we, e_re;
   logic [31:0] e_addr, e_wdata, e_prdata;

   task automatic model_clear();
      aux_waited = 0;
      m_rvalid   = 0;
      m_rdata    = 32'd0;
      m_pcnt     = 0;
      m_acnt     = 0;
   endtask

   task automatic model_decide();
      bit pipe_wants;
      pipe_wants = bus.pipe_read || bus.pipe_write;
      e_gnt   = bus.aux_req && (!pipe_wants || aux_waited >= LIMIT);
      e_go    = pipe_wants && !e_gnt;
      e_stall = pipe_wants && e_gnt;
      e_we = 0; e_re = 0; e_addr = 32'd0; e_wdata = 32'd0; e_prdata = 32'd0;
      if (e_go) begin
         e_we    = bus.pipe_write;
         e_re    = !bus.pipe_write;
         e_addr  = bus.pipe_addr;
         e_wdata = bus.pipe_wdata;
         if (!bus.pipe_write) e_prdata = ref_mem[bus.pipe_addr[9:2]];
      end else if (e_gnt) begin
         e_we    = bus.aux_we;
         e_re    = !bus.aux_we;
         e_addr  = bus.aux_addr;
         e_wdata = bus.aux_wdata;
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         model_clear();
         e_gnt = 0; e_stall = 0; e_we = 0; e_re = 0;
         e_addr = 32'd0; e_wdata = 32'd0; e_prdata = 32'd0;
      end else begin
         model_decide();
      end
      checkOutput("aux_gnt",      {31'd0, bus.aux_gnt},    {31'd0, e_gnt});
      checkOutput("pipe_stall",   {31'd0, bus.pipe_stall}, {31'd0, e_stall});
      checkOutput("mem_we",       {31'd0, bus.mem_we},     {31'd0, e_we});
      checkOutput("mem_re",       {31'd0, bus.mem_re},     {31'd0, e_re});
      checkOutput("mem_addr",     bus.mem_addr,            e_addr);
      checkOutput("mem_wdata",    bus.mem_wdata,           e_wdata);
      checkOutput("pipe_rdata",   bus.pipe_rdata,          e_prdata);
      checkOutput("aux_rvalid",   {31'd0, bus.aux_rvalid}, {31'd0, m_rvalid});
      checkOutput("aux_rdata",    bus.aux_rdata,           m_rdata);
      checkOutput("pipe_acc_cnt", 32'(pipe_acc_cnt),       32'(m_pcnt % (1 << CNT_W)));
      checkOutput("aux_acc_cnt",  32'(aux_acc_cnt),        32'(m_acnt % (1 << CNT_W)));
   end

   always @(posedge clock) begin
      if (reset) begin
         model_clear();
      end else begin
         model_decide();
         m_rvalid = e_gnt && !bus.aux_we;
         if (m_rvalid) m_rdata = ref_mem[bus.aux_addr[9:2]];
         if (e_we) ref_mem[e_addr[9:2]] = e_wdata;
         if (e_gnt) aux_waited = 0;
         else if (bus.aux_req && aux_waited < LIMIT) aux_waited++;
         if (e_go) m_pcnt++;
         if (e_gnt) m_acnt++;
      end
   end

   task automatic applyStimulus(input logic pr, input logic pw, input logic [31:0] pa,
                                input logic [31:0] pwd, input logic ar, input logic awe,
                                input logic [31:0] aa, input logic [31:0] awd);
      @(posedge clock);
      #1;
      bus.pipe_read  = pr;
      bus.pipe_write = pw;
      bus.pipe_addr  = pa;
      bus.pipe_wdata = pwd;
      bus.aux_req    = ar;
      bus.aux_we     = awe;
      bus.aux_addr   = aa;
      bus.aux_wdata  = awd;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      model_clear();
      bus.pipe_read = 0; bus.pipe_write = 0; bus.pipe_addr = 32'd0; bus.pipe_wdata = 32'd0;
      bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = 32'd0; bus.aux_wdata = 32'd0;

      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_pipe_cnt", 32'(pipe_acc_cnt), 32'd0);
      checkOutput("reset_rvalid", {31'd0, bus.aux_rvalid}, 32'd0);

      $display("[TB] pipe-only write then read");
      applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'd0, 32'd0);
      @(negedge clock);
      checkOutput("t1_stall_wr", {31'd0, bus.pipe_stall}, 32'd0);
      applyStimulus(1, 0, 32'h10, 32'd0, 0, 0, 32'd0, 32'd0);
      @(negedge clock);
      checkOutput("t1_rdata", bus.pipe_rdata, 32'hDEADBEEF);
      checkOutput("t1_stall_rd", {31'd0, bus.pipe_stall}, 32'd0);
      idle();
      @(negedge clock);
      checkOutput("t1_pipe_cnt", 32'(pipe_acc_cnt), 32'd2);

      $display("[TB] aux-only write then read");
      applyStimulus(0, 0, 32'd0, 32'd0, 1, 1, 32'h20, 32'h1234);
      @(negedge clock);
      checkOutput("t2_gnt_wr", {31'd0, bus.aux_gnt}, 32'd1);
      applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'h20, 32'd0);
      @(negedge clock);
      checkOutput("t2_gnt_rd", {31'd0, bus.aux_gnt}, 32'd1);
      checkOutput("t2_no_rvalid_wr", {31'd0, bus.aux_rvalid}, 32'd0);
      idle();
      @(negedge clock);
      checkOutput("t2_rvalid", {31'd0, bus.aux_rvalid}, 32'd1);
      checkOutput("t2_rdata", bus.aux_rdata, 32'h1234);
      idle();
      @(negedge clock);
      checkOutput("t2_rvalid_pulse", {31'd0, bus.aux_rvalid}, 32'd0);

      $display("[TB] contention pattern");
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1, 0, 32'h10, 32'd0, 1, 0, 32'h20, 32'd0);
         @(negedge clock);
         checkOutput($sformatf("t3_stall_%0d", i), {31'd0, bus.pipe_stall},
                     (i % 5 == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("t3_gnt_%0d", i), {31'd0, bus.aux_gnt},
                     (i % 5 == 0) ? 32'd1 : 32'd0);
      end
      idle();

      $display("[TB] illegal read+write");
      applyStimulus(1, 1, 32'h30, 32'hCAFEF00D, 0, 0, 32'd0, 32'd0);
      @(negedge clock);
      checkOutput("t4_we", {31'd0, bus.mem_we}, 32'd1);
      checkOutput("t4_re", {31'd0, bus.mem_re}, 32'd0);
      checkOutput("t4_rdata", bus.pipe_rdata, 32'd0);
      idle();

      $display("[TB] async reset during aux read");
      applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'h20, 32'd0);
      #1 reset = 1'b1;
      @(negedge clock);
      checkOutput("t5_we", {31'd0, bus.mem_we}, 32'd0);
      checkOutput("t5_re", {31'd0, bus.mem_re}, 32'd0);
      checkOutput("t5_gnt", {31'd0, bus.aux_gnt}, 32'd0);
      checkOutput("t5_pipe_cnt", 32'(pipe_acc_cnt), 32'd0);
      checkOutput("t5_aux_cnt", 32'(aux_acc_cnt), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      bus.aux_req = 0;
      @(negedge clock);
      checkOutput("t5_rvalid", {31'd0, bus.aux_rvalid}, 32'd0);
      checkOutput("t5_rdata", bus.aux_rdata, 32'd0);

      $display("[TB] counter wrap");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(0, 1, 32'(i * 4), 32'(i), 0, 0, 32'd0, 32'd0);
      end
      idle();
      @(negedge clock);
      checkOutput("t6_wrap", 32'(pipe_acc_cnt), 32'd1);

      idle();
      idle();
      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
